clint_timer: RTL and testbench

- Memory-mapped core-local interrupt source.
- Holds the 64-bit machine timer (mtime), the compare register (mtimecmp) and the software-interrupt bit (msip).
- Drives the timer_int and sw_int request lines consumed by the interrupt controller, which feed mip.MTIP and mip.MSIP.
- Sits on the CPU data-memory bus as a single-cycle slave.

---
 rtl/clint_timer_pkg.sv | 40 ++++
 rtl/clint_prescaler.sv | 29 ++
 rtl/clint_timer.sv | 138 +++++++++++++
 tb/tb_clint_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_pkg.sv
// Shared register offsets, reset constants and address decode for the CLINT timer block.
package clint_timer_pkg;

   // Byte offsets of the architected registers inside the block
   localparam logic [4:0] CLINT_MSIP        = 5'h00;
   localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] CLINT_MTIME_LO    = 5'h10;
   localparam logic [4:0] CLINT_MTIME_HI    = 5'h14;
   localparam logic [4:0] CLINT_PRESCALE    = 5'h18;

   // Compare register starts at all-ones so no timer interrupt fires out of reset
   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_MT_LO,
      REG_MT_HI,
      REG_PRE,
      REG_NONE
   } reg_sel_e;

   // Word index (byte offset [4:2]) to register select; holes map to REG_NONE
   function automatic reg_sel_e decode_word(input logic [2:0] word);
      reg_sel_e sel;
      case ({word, 2'b00})
         CLINT_MSIP:        sel = REG_MSIP;
         CLINT_MTIMECMP_LO: sel = REG_CMP_LO;
         CLINT_MTIMECMP_HI: sel = REG_CMP_HI;
         CLINT_MTIME_LO:    sel = REG_MT_LO;
         CLINT_MTIME_HI:    sel = REG_MT_HI;
         CLINT_PRESCALE:    sel = REG_PRE;
         default:           sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator: counts 0..prescale and pulses tick on the terminal count.
module clint_prescaler
   import clint_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt;

   // Terminal count reached; prescale=0 therefore ticks every cycle
   assign tick = (cnt == prescale);

   // Counter restarts after each tick and whenever the prescale value is rewritten
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/clint_timer.sv
// Core-local timer/software interrupt source: mtime, mtimecmp, msip and a
// tick prescaler behind a single-cycle 32-bit slave port.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter int BASE_SEL   = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bus_req,
   input  logic                bus_we,
   input  logic [BASE_SEL-1:0] bus_addr,
   input  logic [31:0]         bus_wdata,
   output logic                bus_ack,
   output logic [31:0]         bus_rdata,
   output logic                timer_int,
   output logic                sw_int
);

   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  msip;
   logic [PRESCALE_W-1:0] prescale;
   logic                  tick;
   logic                  addr_in_block;
   reg_sel_e              sel;
   logic [31:0]           rd_val;
   logic                  wr_hit;
   logic                  rd_hit;
   logic                  wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi, wr_pre;

   // Byte-lane bits are don't-care: only full-word accesses exist
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus_addr[1:0];

   // Any address bits above the 32-byte window must be zero to hit a register
   if (BASE_SEL > 5) begin : g_hi_addr
      assign addr_in_block = ~|bus_addr[BASE_SEL-1:5];
   end else begin : g_no_hi_addr
      assign addr_in_block = 1'b1;
   end

   assign sel    = addr_in_block ? decode_word(bus_addr[4:2]) : REG_NONE;
   assign wr_hit = bus_req &  bus_we;
   assign rd_hit = bus_req & ~bus_we;

   assign wr_msip   = wr_hit & (sel == REG_MSIP);
   assign wr_cmp_lo = wr_hit & (sel == REG_CMP_LO);
   assign wr_cmp_hi = wr_hit & (sel == REG_CMP_HI);
   assign wr_mt_lo  = wr_hit & (sel == REG_MT_LO);
   assign wr_mt_hi  = wr_hit & (sel == REG_MT_HI);
   assign wr_pre    = wr_hit & (sel == REG_PRE);

   clint_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .prescale (prescale),
      .clr      (wr_pre),
      .tick     (tick)
   );

   // Read mux over current register values (pre-update view)
   always_comb begin
      rd_val = '0;
      case (sel)
         REG_MSIP:   rd_val = {31'd0, msip};
         REG_CMP_LO: rd_val = mtimecmp[31:0];
         REG_CMP_HI: rd_val = mtimecmp[63:32];
         REG_MT_LO:  rd_val = mtime[31:0];
         REG_MT_HI:  rd_val = mtime[63:32];
         REG_PRE:    rd_val = 32'(prescale);
         default:    rd_val = '0;
      endcase
   end

   // Single-cycle slave: every request is acked on the next edge, read data rides with the ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_ack   <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ack   <= bus_req;
         bus_rdata <= rd_hit ? rd_val : 32'd0;
      end
   end

   // Software interrupt pending bit; only bit 0 of the write data is kept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         msip <= 1'b0;
      else if (wr_msip)
         msip <= bus_wdata[0];
   end

   // Prescale register; narrower than the bus, upper write bits are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prescale <= '0;
      else if (wr_pre)
         prescale <= bus_wdata[PRESCALE_W-1:0];
   end

   // Compare register, written one 32-bit half per access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mtimecmp <= MTIMECMP_RESET;
      else if (wr_cmp_lo)
         mtimecmp[31:0] <= bus_wdata;
      else if (wr_cmp_hi)
         mtimecmp[63:32] <= bus_wdata;
   end

   // Machine timer: a write to either half wins over (and consumes) that cycle's tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mtime <= '0;
      else if (wr_mt_lo)
         mtime[31:0] <= bus_wdata;
      else if (wr_mt_hi)
         mtime[63:32] <= bus_wdata;
      else if (tick)
         mtime <= mtime + 64'd1;
   end

   // Timer request is a registered unsigned compare of the current register values
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timer_int <= 1'b0;
      else
         timer_int <= (mtime >= mtimecmp);
   end

   assign sw_int = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed plus randomized bench for clint_timer with a cycle-level behavioural model.
module tb_clint_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [4:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        timer_int;
   logic        sw_int;

   int ntests = 0;
   int nfail  = 0;

   clint_timer #(.PRESCALE_W(16), .BASE_SEL(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .timer_int (timer_int),
      .sw_int    (sw_int)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- behavioural model ----------------
   // Ticks occur whenever the number of cycles since the last prescale write
   // (or reset) is congruent to prescale modulo prescale+1.
   logic [63:0] m_mt, m_cmp;
   bit          m_msip;
   int unsigned m_pre;
   int unsigned m_since;
   bit          m_tick, m_mt_wr;
   bit          e_ack, e_tint;
   logic [31:0] e_rd;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a & 5'h1C)
         5'h00:   return {31'd0, m_msip};
         5'h08:   return m_cmp[31:0];
         5'h0C:   return m_cmp[63:32];
         5'h10:   return m_mt[31:0];
         5'h14:   return m_mt[63:32];
         5'h18:   return m_pre;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mt = 64'd0; m_cmp = '1; m_msip = 0; m_pre = 0; m_since = 0;
         e_ack = 0; e_rd = 0; e_tint = 0;
      end else begin
         m_tick  = (m_since % (m_pre + 1)) == m_pre;
         e_tint  = (m_mt >= m_cmp);
         e_ack   = bus_req;
         e_rd    = (bus_req && !bus_we) ? m_read(bus_addr) : 32'd0;
         m_since = m_since + 1;
         m_mt_wr = 0;
         if (bus_req && bus_we) begin
            case (bus_addr & 5'h1C)
               5'h00: m_msip = bus_wdata[0];
               5'h08: m_cmp[31:0] = bus_wdata;
               5'h0C: m_cmp[63:32] = bus_wdata;
               5'h10: begin m_mt[31:0] = bus_wdata; m_mt_wr = 1; end
               5'h14: begin m_mt[63:32] = bus_wdata; m_mt_wr = 1; end
               5'h18: begin m_pre = bus_wdata[15:0]; m_since = 0; end
               default: ;
            endcase
         end
         if (!m_mt_wr && m_tick) m_mt = m_mt + 64'd1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and compare every output against the model
   task automatic cyc();
      @(negedge clk);
      chk("ack",       bus_ack,   e_ack);
      chk("rdata",     bus_rdata, e_rd);
      chk("timer_int", timer_int, e_tint);
      chk("sw_int",    sw_int,    m_msip);
   endtask

   // One access; leaves the bus idle so a following call is back-to-back
   task automatic bus(input bit we, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
      cyc();
      chk("ack_pulse", bus_ack, 1'b1);
      rd = bus_rdata;
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   logic [31:0] r;
   bit          found;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", bus_ack, 1'b0);
      chk("rst_rdata", bus_rdata, 32'd0);
      chk("rst_tint", timer_int, 1'b0);
      chk("rst_sw", sw_int, 1'b0);
      reset = 1'b1;

      bus(0, 5'h08, 0, r); chk("cmp_lo_rst", r, 32'hFFFF_FFFF);
      bus(0, 5'h0C, 0, r); chk("cmp_hi_rst", r, 32'hFFFF_FFFF);
      bus(0, 5'h18, 0, r); chk("pre_rst", r, 32'd0);
      cyc(); chk("ack_drops", bus_ack, 1'b0);

      // Timer compare rise and fall, prescale 0
      bus(1, 5'h0C, 32'd0, r);
      bus(1, 5'h10, 32'd0, r);
      bus(1, 5'h08, 32'd20, r);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc();
         if (timer_int) found = 1;
      end
      chk("tint_rise_seen", found, 1'b1);
      bus(0, 5'h10, 0, r); chk("mtime_at_rise", r, 32'd21);
      bus(1, 5'h08, 32'd1000, r); chk("tint_still_high", timer_int, 1'b1);
      cyc(); chk("tint_dropped", timer_int, 1'b0);

      // Prescale 3: one tick every 4 cycles
      bus(1, 5'h18, 32'd3, r);
      bus(1, 5'h10, 32'd0, r);
      bus(1, 5'h14, 32'd0, r);
      repeat (40) cyc();
      bus(0, 5'h10, 0, r); chk("mtime_prescaled", r, 32'd10);
      bus(0, 5'h18, 0, r); chk("pre_readback", r, 32'd3);

      // 64-bit wrap and LO->HI carry
      bus(1, 5'h18, 32'd0, r);
      bus(1, 5'h10, 32'hFFFF_FFFF, r);
      bus(1, 5'h14, 32'hFFFF_FFFF, r);
      bus(0, 5'h10, 0, r); chk("wrap_lo_before", r, 32'hFFFF_FFFF);
      bus(0, 5'h14, 0, r); chk("wrap_hi_after", r, 32'd0);
      bus(1, 5'h10, 32'hFFFF_FFFF, r);
      bus(0, 5'h14, 0, r); chk("carry_hi_before", r, 32'd0);
      bus(0, 5'h14, 0, r); chk("carry_hi_after", r, 32'd1);
      bus(0, 5'h10, 0, r); chk("carry_lo_after", r, 32'd1);

      // Software interrupt
      bus(1, 5'h00, 32'hFFFF_FFFF, r); chk("sw_set", sw_int, 1'b1);
      bus(0, 5'h00, 0, r); chk("msip_read", r, 32'd1);
      bus(1, 5'h00, 32'd0, r); chk("sw_clr", sw_int, 1'b0);

      // Unmapped offsets
      bus(1, 5'h1C, 32'hDEAD_BEEF, r); chk("hole1c_wr_rd", r, 32'd0);
      bus(1, 5'h04, 32'h1234_5678, r);
      bus(0, 5'h1C, 0, r); chk("hole1c_read", r, 32'd0);
      bus(0, 5'h04, 0, r); chk("hole04_read", r, 32'd0);
      bus(0, 5'h08, 0, r); chk("cmp_lo_kept", r, 32'd1000);
      bus(0, 5'h00, 0, r); chk("msip_kept", r, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            cyc();
         end else begin
            logic [4:0]  a;
            logic [31:0] d;
            bit          w;
            a = 5'($urandom_range(0, 7) * 4);
            w = $urandom_range(0, 1) == 1;
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
            if (a == 5'h18) d = $urandom_range(0, 5);
            if (a == 5'h0C || a == 5'h14) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            bus(w, a, d, r);
         end
      end

      // Reset asserted while a write is in flight
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'h00; bus_wdata = 32'd1;
      #2 reset = 1'b0;
      @(negedge clk);
      chk("midrst_ack", bus_ack, 1'b0);
      chk("midrst_rdata", bus_rdata, 32'd0);
      chk("midrst_sw", sw_int, 1'b0);
      chk("midrst_tint", timer_int, 1'b0);
      bus_req = 1'b0; bus_we = 1'b0;
      reset = 1'b1;
      bus(0, 5'h00, 0, r); chk("midrst_msip", r, 32'd0);
      bus(0, 5'h08, 0, r); chk("midrst_cmp_lo", r, 32'hFFFF_FFFF);
      bus(0, 5'h0C, 0, r); chk("midrst_cmp_hi", r, 32'hFFFF_FFFF);
      bus(0, 5'h18, 0, r); chk("midrst_pre", r, 32'd0);
      bus(0, 5'h14, 0, r); chk("midrst_mt_hi", r, 32'd0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
